addsub_rr_scheduler: RTL

- Shares one n_bit_adder_subtractor datapath among NREQ requesters.
- Each requester submits an operand pair plus an add/sub control bit over a valid/ready handshake.
- A round-robin arbiter picks one request, drives the shared datapath from registered operands, and captures answer/overflow.
- The result is returned on a single response channel, tagged with the requester id.

---
 rtl/addsub_rr_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler that time-shares one external adder/subtractor among NREQ requesters.
// Requests are served one at a time: grant (IDLE), datapath evaluate (EXEC), response hold (RESP).
`timescale 1ns/1ps
module addsub_rr_scheduler #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_ctrl,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      dp_a,
  output logic [WIDTH-1:0]      dp_b,
  output logic                  dp_ctrl,
  input  logic [WIDTH-1:0]      dp_answer,
  input  logic                  dp_overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_answer,
  output logic                  rsp_overflow
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_ctrl_q, op_ctrl_d;
  logic [IDW-1:0]   op_id_q, op_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_answer_q, rsp_answer_d;
  logic             rsp_overflow_q, rsp_overflow_d;

  logic             found_hi, found_lo;
  logic [IDW-1:0]   idx_hi, idx_lo;
  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_ctrl;

  // Round-robin pick: first valid index above last_grant, else lowest valid index (wrap).
  always_comb begin : arbiter
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_valid[i] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = IDW'(i);
      end
      if (req_valid[i] && !found_hi && (IDW'(i) > last_grant_q)) begin
        found_hi = 1'b1;
        idx_hi   = IDW'(i);
      end
    end
    grant_vld = found_lo;
    grant_idx = found_hi ? idx_hi : idx_lo;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a    = req_a[i*int'(WIDTH) +: WIDTH];
        sel_b    = req_b[i*int'(WIDTH) +: WIDTH];
        sel_ctrl = req_ctrl[i];
      end
    end
  end

  // Grant is combinational and forced low while reset is asserted.
  always_comb begin : ready_gen
    req_ready = '0;
    if ((state_q == IDLE) && grant_vld && rst_n) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

  always_comb begin : next_state
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_ctrl_d      = op_ctrl_q;
    op_id_d        = op_id_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_answer_d   = rsp_answer_q;
    rsp_overflow_d = rsp_overflow_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          op_a_d       = sel_a;
          op_b_d       = sel_b;
          op_ctrl_d    = sel_ctrl;
          op_id_d      = grant_idx;
          last_grant_d = grant_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_answer_d   = dp_answer;
        rsp_overflow_d = dp_overflow;
        rsp_id_d       = op_id_q;
        rsp_valid_d    = 1'b1;
        state_d        = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_grant_q   <= IDW'(NREQ - 1);
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_ctrl_q      <= 1'b0;
      op_id_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_answer_q   <= '0;
      rsp_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_ctrl_q      <= op_ctrl_d;
      op_id_q        <= op_id_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_answer_q   <= rsp_answer_d;
      rsp_overflow_q <= rsp_overflow_d;
    end
  end

  assign dp_a         = op_a_q;
  assign dp_b         = op_b_q;
  assign dp_ctrl      = op_ctrl_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_answer   = rsp_answer_q;
  assign rsp_overflow = rsp_overflow_q;

endmodule
